// File: rtl/key_switch_input_if.sv
// Wishbone classic slave bus for the key/switch input block.
// Signal names are from the slave's point of view.
interface key_switch_input_if;
   logic        cyc_i;
   logic        stb_i;
   logic        we_i;
   logic [1:0]  adr_i;
   logic [31:0] dat_i;
   logic [3:0]  sel_i;
   logic [31:0] dat_o;
   logic        ack_o;

   modport master (
      output cyc_i, stb_i, we_i, adr_i, dat_i, sel_i,
      input  dat_o, ack_o
   );

   modport slave (
      input  cyc_i, stb_i, we_i, adr_i, dat_i, sel_i,
      output dat_o, ack_o
   );
endinterface

// File: rtl/key_switch_input.sv
// Synchronized, debounced pushbuttons and slide switches with a press latch,
// an interrupt mask and a Wishbone classic register interface.
module key_switch_input #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned NKEY            = 4,
   parameter int unsigned NSW             = 10
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [NKEY-1:0]     key_i,
   input  logic [NSW-1:0]      sw_i,
   key_switch_input_if.slave   bus,
   output logic                irq_o
);

   localparam int unsigned NB = NSW + NKEY;
   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   // Bit layout of all per-input vectors: keys on top, switches below.
   logic [NB-1:0]   meta_q;
   logic [NB-1:0]   sync_q;
   logic [NB-1:0]   level;
   logic [NB-1:0]   stable_q;
   logic [NB-1:0]   stable_d;
   logic [CW-1:0]   cnt_q [NB];
   logic [CW-1:0]   cnt_d [NB];
   logic [NKEY-1:0] pend_q;
   logic [NKEY-1:0] pend_d;
   logic [NKEY-1:0] mask_q;
   logic [NKEY-1:0] mask_d;
   logic [NKEY-1:0] clr;
   logic [31:0]     rd;
   logic [31:0]     dat_q;
   logic [31:0]     dat_d;
   logic            ack_q;
   logic            irq_q;
   logic            req;
   logic            wr;

   // Keys are active-low at the pin; inversion happens after synchronization.
   assign level = {~sync_q[NB-1:NSW], sync_q[NSW-1:0]};

   always_comb begin
      stable_d = stable_q;
      for (int unsigned b = 0; b < NB; b++) begin
         cnt_d[b] = '0;
         if (level[b] != stable_q[b]) begin
            if (cnt_q[b] == CNT_MAX) stable_d[b] = level[b];
            else                     cnt_d[b]    = cnt_q[b] + 1'b1;
         end
      end
   end

   assign req = bus.cyc_i & bus.stb_i & ~ack_q;
   assign wr  = req & bus.we_i & bus.sel_i[0];

   always_comb begin
      rd = '0;
      case (bus.adr_i)
         2'd0:    rd[NSW-1:0]  = stable_q[NSW-1:0];
         2'd1:    rd[NKEY-1:0] = stable_q[NB-1:NSW];
         2'd2:    rd[NKEY-1:0] = pend_q;
         default: rd[NKEY-1:0] = mask_q;
      endcase

      clr    = '0;
      mask_d = mask_q;
      if (wr && bus.adr_i == 2'd2) clr    = bus.dat_i[NKEY-1:0];
      if (wr && bus.adr_i == 2'd3) mask_d = bus.dat_i[NKEY-1:0];

      // A press edge in the clearing cycle wins over the clear.
      pend_d = (pend_q & ~clr) | (stable_d[NB-1:NSW] & ~stable_q[NB-1:NSW]);
      dat_d  = req ? rd : '0;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         meta_q   <= '0;
         sync_q   <= '0;
         stable_q <= '0;
         cnt_q    <= '{default: '0};
         pend_q   <= '0;
         mask_q   <= '0;
         dat_q    <= '0;
         ack_q    <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         meta_q   <= {key_i, sw_i};
         sync_q   <= meta_q;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
         pend_q   <= pend_d;
         mask_q   <= mask_d;
         dat_q    <= dat_d;
         ack_q    <= req;
         irq_q    <= |(pend_q & mask_q);
      end
   end

   assign bus.ack_o = ack_q;
   assign bus.dat_o = dat_q;
   assign irq_o     = irq_q;

endmodule

// File: tb/tb_key_switch_input.sv
// Scoreboard bench for key_switch_input: window-based debounce reference model,
// directed scenarios followed by randomized pin and bus traffic.
module tb_key_switch_input;

   localparam int unsigned D    = 4;
   localparam int unsigned NKEY = 4;
   localparam int unsigned NSW  = 10;
   localparam int unsigned NB   = NSW + NKEY;

   logic            clk = 1'b0;
   logic            rst;
   logic [NKEY-1:0] key;
   logic [NSW-1:0]  sw;
   logic            irq;

   key_switch_input_if bus_if ();

   key_switch_input #(
      .DEBOUNCE_CYCLES(D),
      .NKEY           (NKEY),
      .NSW            (NSW)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .key_i(key),
      .sw_i (sw),
      .bus  (bus_if),
      .irq_o(irq)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic        chk;
      logic [31:0] dat;
   } exp_t;

   exp_t expq[$];

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endfunction

   // Reference model: a level is accepted once the last D synchronized
   // samples all disagree with the accepted level.
   logic [NB-1:0]   raw1 = '0;
   logic [NB-1:0]   raw2 = '0;
   logic            rst1 = 1'b1;
   logic            rst2 = 1'b1;
   logic [NB-1:0]   shist[$];
   logic [NB-1:0]   m_stable = '0;
   logic [NKEY-1:0] m_pend   = '0;
   logic [NKEY-1:0] m_mask   = '0;
   logic            m_ack    = 1'b0;
   logic            m_irq    = 1'b0;
   bit              mon_en   = 1'b0;

   always @(posedge clk) begin : model
      logic [NB-1:0]   sraw;
      logic [NB-1:0]   lvl;
      logic [NB-1:0]   nstable;
      logic [NKEY-1:0] rise;
      logic [NKEY-1:0] clr;
      logic [31:0]     rd;
      logic            req;
      logic            wr;
      bit              all;
      if (rst) begin
         shist.delete();
         m_stable = '0;
         m_pend   = '0;
         m_mask   = '0;
         m_ack    = 1'b0;
         m_irq    = 1'b0;
         mon_en   = 1'b1;
      end else begin
         sraw = (rst1 || rst2) ? '0 : raw2;
         lvl  = {~sraw[NB-1:NSW], sraw[NSW-1:0]};
         shist.push_back(lvl);
         if (shist.size() > D) void'(shist.pop_front());
         nstable = m_stable;
         if (shist.size() == D) begin
            for (int b = 0; b < NB; b++) begin
               all = 1'b1;
               foreach (shist[i]) if (shist[i][b] == m_stable[b]) all = 1'b0;
               if (all) nstable[b] = ~m_stable[b];
            end
         end
         rise = nstable[NB-1:NSW] & ~m_stable[NB-1:NSW];

         req = bus_if.cyc_i & bus_if.stb_i & ~m_ack;
         wr  = req & bus_if.we_i & bus_if.sel_i[0];
         rd  = '0;
         case (bus_if.adr_i)
            2'd0:    rd[NSW-1:0]  = m_stable[NSW-1:0];
            2'd1:    rd[NKEY-1:0] = m_stable[NB-1:NSW];
            2'd2:    rd[NKEY-1:0] = m_pend;
            default: rd[NKEY-1:0] = m_mask;
         endcase
         if (req) expq.push_back('{chk: ~bus_if.we_i, dat: rd});

         clr = (wr && bus_if.adr_i == 2'd2) ? bus_if.dat_i[NKEY-1:0] : '0;
         m_irq  = |(m_pend & m_mask);
         m_pend = (m_pend & ~clr) | rise;
         if (wr && bus_if.adr_i == 2'd3) m_mask = bus_if.dat_i[NKEY-1:0];
         m_stable = nstable;
         m_ack    = req;
      end
      raw2 = raw1;
      raw1 = {key, sw};
      rst2 = rst1;
      rst1 = rst;
   end

   always @(negedge clk) begin : monitor
      exp_t e;
      if (mon_en) begin
         check("ack", 32'(bus_if.ack_o), 32'(m_ack));
         check("irq", 32'(irq), 32'(m_irq));
         if (bus_if.ack_o === 1'b1) begin
            if (expq.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_ack: got ack=1 expected no pending response at %0t", $time);
            end else begin
               e = expq.pop_front();
               if (e.chk) check("rdata", bus_if.dat_o, e.dat);
            end
         end else begin
            check("idle_dat", bus_if.dat_o, 32'h0);
         end
      end
   end

   task automatic cycles(input int unsigned n);
      repeat (n) @(negedge clk);
   endtask

   // Call at a negedge; returns at the negedge where ack is seen.
   task automatic xfer(input logic w, input logic [1:0] a, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] r);
      int unsigned n = 0;
      bus_if.cyc_i = 1'b1;
      bus_if.stb_i = 1'b1;
      bus_if.we_i  = w;
      bus_if.adr_i = a;
      bus_if.dat_i = d;
      bus_if.sel_i = s;
      do begin
         @(negedge clk);
         n++;
      end while (bus_if.ack_o !== 1'b1 && n < 8);
      if (bus_if.ack_o !== 1'b1) begin
         checks++;
         failures++;
         $display("FAIL xfer_timeout: got ack=%b expected 1 within 8 cycles", bus_if.ack_o);
      end
      r = bus_if.dat_o;
      bus_if.cyc_i = 1'b0;
      bus_if.stb_i = 1'b0;
      bus_if.we_i  = 1'b0;
   endtask

   task automatic rd_check(string name, input logic [1:0] a, input logic [31:0] exp);
      logic [31:0] r;
      xfer(1'b0, a, 32'h0, 4'hF, r);
      check(name, r, exp);
   endtask

   task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
      logic [31:0] r;
      xfer(1'b1, a, d, 4'hF, r);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0]  pat;
      logic [31:0] dat_on_ack;
      rst          = 1'b1;
      key          = '1;
      sw           = 10'h2A5;
      bus_if.cyc_i = 1'b0;
      bus_if.stb_i = 1'b0;
      bus_if.we_i  = 1'b0;
      bus_if.adr_i = 2'd0;
      bus_if.dat_i = '0;
      bus_if.sel_i = '0;
      cycles(3);
      check("reset_irq", 32'(irq), 32'h0);
      check("reset_ack", 32'(bus_if.ack_o), 32'h0);
      rst = 1'b0;

      // Switches on through reset: visible only after 2 + D edges.
      rd_check("reg0_edge1", 2'd0, 32'h0);
      cycles(4);
      rd_check("reg0_edge6", 2'd0, 32'h0);
      rd_check("reg0_edge7", 2'd0, 32'h0000_02A5);

      // Glitch of 3 cycles on key 1.
      key = 4'b1101;
      cycles(3);
      key = 4'b1111;
      cycles(10);
      rd_check("glitch_key", 2'd1, 32'h0);
      rd_check("glitch_pend", 2'd2, 32'h0);
      check("glitch_irq", 32'(irq), 32'h0);

      // Held press with mask on key 1.
      wr_reg(2'd3, 32'hFFFF_FFF2);
      rd_check("mask_rd", 2'd3, 32'h2);
      key = 4'b1101;
      cycles(20);
      rd_check("press_key", 2'd1, 32'h2);
      rd_check("press_pend", 2'd2, 32'h2);
      check("press_irq", 32'(irq), 32'h1);

      // Write-1-to-clear; irq drops one cycle after pend.
      wr_reg(2'd2, 32'h2);
      check("clr_irq_hold", 32'(irq), 32'h1);
      @(negedge clk);
      check("clr_irq_fall", 32'(irq), 32'h0);
      rd_check("clr_pend", 2'd2, 32'h0);

      // Press edge landing on the clearing write.
      key = 4'b1111;
      cycles(12);
      rd_check("release_pend", 2'd2, 32'h0);
      key = 4'b1101;
      cycles(5);
      wr_reg(2'd2, 32'h2);
      rd_check("race_pend", 2'd2, 32'h2);
      key = 4'b1111;
      cycles(12);
      wr_reg(2'd2, 32'hF);

      // Strobe held on a register 3 read.
      cycles(2);
      bus_if.cyc_i = 1'b1;
      bus_if.stb_i = 1'b1;
      bus_if.we_i  = 1'b0;
      bus_if.adr_i = 2'd3;
      pat[3] = bus_if.ack_o;
      @(negedge clk);
      pat[2] = bus_if.ack_o;
      dat_on_ack = bus_if.dat_o;
      @(negedge clk);
      pat[1] = bus_if.ack_o;
      @(negedge clk);
      pat[0] = bus_if.ack_o;
      bus_if.cyc_i = 1'b0;
      bus_if.stb_i = 1'b0;
      check("held_stb_ack", 32'(pat), 32'h5);
      check("held_stb_dat", dat_on_ack, 32'h2);

      // Reset landing on the ack edge of a mask write.
      cycles(2);
      bus_if.cyc_i = 1'b1;
      bus_if.stb_i = 1'b1;
      bus_if.we_i  = 1'b1;
      bus_if.adr_i = 2'd3;
      bus_if.dat_i = 32'hF;
      bus_if.sel_i = 4'h1;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      bus_if.cyc_i = 1'b0;
      bus_if.stb_i = 1'b0;
      bus_if.we_i  = 1'b0;
      check("rst_ack", 32'(bus_if.ack_o), 32'h0);
      rd_check("rst_mask", 2'd3, 32'h0);

      // Randomized pins and bus traffic.
      fork
         begin
            for (int c = 0; c < 1500; c++) begin
               @(negedge clk);
               if ($urandom_range(0, 9) == 0) begin
                  int k = int'($urandom_range(0, NSW - 1));
                  sw[k] = ~sw[k];
               end
               if ($urandom_range(0, 5) == 0) begin
                  int k = int'($urandom_range(0, NKEY - 1));
                  key[k] = ~key[k];
               end
            end
         end
         begin
            for (int t = 0; t < 250; t++) begin
               logic [31:0] r;
               cycles($urandom_range(0, 3));
               if ($urandom_range(0, 2) == 0)
                  xfer(1'b1, 2'($urandom_range(0, 3)), $urandom, 4'($urandom), r);
               else
                  xfer(1'b0, 2'($urandom_range(0, 3)), 32'h0, 4'hF, r);
            end
         end
      join

      cycles(5);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/key_switch_input.md
KEY_SWITCH_INPUT -- requirements
Module: key_switch_input

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, cycles an input must hold a new level before it is accepted (10 ms at 50 MHz); legal range 2..2^20.
REQ-002 Parameter NKEY, default 4, number of pushbuttons.
REQ-003 Parameter NSW, default 10, number of slide switches.
REQ-004 clk_i  input  1  sole clock; one clock domain.
REQ-005 rst_i  input  1  reset, synchronous, active-high.
REQ-006 key_i  input  NKEY  raw pushbuttons, asynchronous, active-low (0 = pressed).
REQ-007 sw_i  input  NSW  raw slide switches, asynchronous, active-high.
REQ-008 cyc_i, stb_i, we_i  input  1 each  Wishbone classic slave cycle, strobe and write-enable.
REQ-009 adr_i  input  2  word address selecting register 0..3.
REQ-010 dat_i  input  32  write data.
REQ-011 sel_i  input  4  byte lanes; writes take effect only when sel_i[0]=1.
REQ-012 dat_o  output  32  read data.
REQ-013 ack_o  output  1  Wishbone acknowledge.
REQ-014 irq_o  output  1  level interrupt, active-high.

Function
REQ-015 Each key_i and sw_i bit passes through a 2-flop synchronizer before any other use; key bits are inverted after synchronization (1 = pressed).
REQ-016 Each bit has its own debounce counter and a stable register; if the synchronized bit equals stable, counter clears to 0.
REQ-017 If the synchronized bit differs from stable, counter increments; when counter = DEBOUNCE_CYCLES-1 while still differing, stable takes the new level and counter clears in the same cycle.
REQ-018 A glitch shorter than DEBOUNCE_CYCLES cycles (bit returns before threshold) leaves stable unchanged and restarts the count on the next difference.
REQ-019 Total latency from raw-pin change to stable change: 2 synchronizer cycles + DEBOUNCE_CYCLES cycles.
REQ-020 Press latch: bit n of pend[NKEY-1:0] sets in the cycle stable key n transitions 0->1; release (1->0) does not set it.
REQ-021 Register 0 (read-only): {zeros, stable_sw[NSW-1:0]}.
REQ-022 Register 1 (read-only): {zeros, stable_key[NKEY-1:0]}.
REQ-023 Register 2: read returns {zeros, pend}; write clears each pend bit whose dat_i bit is 1 (write-1-to-clear); a set and a clear of the same bit in the same cycle leave the bit set.
REQ-024 Register 3: read/write irq mask[NKEY-1:0]; upper dat_i bits ignored.
REQ-025 Writes to registers 0 and 1 are acknowledged and have no effect.
REQ-026 Bus handshake: when cyc_i & stb_i & ~ack_o, ack_o asserts on the next clock for exactly one cycle; the write takes effect in the same clock edge that raises ack_o; dat_o is valid while ack_o=1 and 0 otherwise.
REQ-027 A strobe held across consecutive cycles yields ack every second cycle (ack, idle, ack, ...); there are no wait states beyond this.
REQ-028 irq_o is registered: irq_o = |(pend & mask) from the previous cycle, i.e. one cycle after pend or mask changes.

Reset
REQ-029 While rst_i=1 at a clock edge: synchronizers, counters, stable_sw, stable_key, pend, mask, dat_o, ack_o and irq_o all become 0.
REQ-030 Reset asserted mid-transaction drops ack_o and discards the write; reset asserted mid-debounce discards the count.
REQ-031 After reset, switches already ON appear in register 0 only after the full REQ-019 latency; keys held through reset produce a pend bit once debounced.

Verification (bench uses DEBOUNCE_CYCLES=4)
REQ-032 Reset, sw_i=10'h2A5 held -> register 0 reads 0 until cycle 6 after reset release, then 32'h0000_02A5.
REQ-033 key_i[1] pulled low for 3 cycles, then high -> stable_key stays 0, pend stays 0, irq_o stays 0.
REQ-034 mask=4'h2, key_i[1] low for 20 cycles -> register 1 reads 4'h2, pend=4'h2, irq_o rises 1 cycle after pend.
REQ-035 Write 32'h2 to register 2 -> pend=0, irq_o falls next cycle; repeating with a press edge landing on the write cycle -> pend bit remains 1.
REQ-036 stb_i held high on register 3 read for 4 cycles -> ack_o pattern 0,1,0,1; dat_o equals mask only on ack cycles.
REQ-037 rst_i asserted for 1 cycle during a write to register 3 at the ack edge -> ack_o=0 and mask=0 afterward.
